// File: rtl/alu_operand_ctrl_if.sv
// Instruction handshake bus for alu_operand_ctrl.
// The issuing side (master) presents one instruction and holds it until ready is seen.
interface alu_operand_ctrl_if #(
  parameter int n  = 4,
  parameter int AW = 2
);
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_ra;
  logic [AW-1:0] instr_rb;
  logic          instr_imm_en;
  logic [n-1:0]  instr_imm;
  logic          instr_cin;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_ra, instr_rb,
           instr_imm_en, instr_imm, instr_cin,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb,
           instr_imm_en, instr_imm, instr_cin,
    output instr_ready
  );
endinterface

// File: rtl/alu_operand_ctrl.sv
// Operand/control stage in front of an n-bit ALU (AND/OR/ADD/SUB with Z/C flags).
// One instruction is taken per IDLE->EXEC->WB pass: operands are read from the
// register file at accept, the ALU settles during EXEC, and the result plus flags
// are captured at the edge that ends WB.
module alu_operand_ctrl #(
  parameter  int n    = 4,
  parameter  int NREG = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_operand_ctrl_if.slave  instr,
  output logic [n-1:0]       ALUA,
  output logic [n-1:0]       ALUB,
  output logic [3:0]         ALUcontrol,
  output logic               ALUFLAGin,
  input  logic [n-1:0]       ALUresult,
  input  logic [1:0]         ALUflags,
  output logic               wb_valid,
  output logic [n-1:0]       wb_data,
  output logic               err,
  output logic               flag_z,
  output logic               flag_c,
  input  logic [AW-1:0]      dbg_addr,
  output logic [n-1:0]       dbg_data
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [n-1:0]  rf [NREG];
  logic [AW-1:0] rd_q;

  logic          accept;
  logic          op_legal;
  logic          op_arith;
  logic [n-1:0]  operand_b;
  logic          carry_in;

  assign instr.instr_ready = (state_q == IDLE);
  assign dbg_data          = rf[dbg_addr];

  // Decode the presented instruction: legality, B operand source and carry-in choice.
  always_comb begin
    accept    = instr.instr_valid && (state_q == IDLE);
    op_legal  = 1'b0;
    op_arith  = 1'b0;
    case (instr.instr_op)
      OP_AND, OP_OR:   op_legal = 1'b1;
      OP_ADD, OP_SUB: begin
        op_legal = 1'b1;
        op_arith = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
    operand_b = instr.instr_imm_en ? instr.instr_imm : rf[instr.instr_rb];
    // Logic ops get the held C so the ALU can pass it through unchanged.
    if (op_arith) begin
      carry_in = instr.instr_cin ? flag_c : 1'b0;
    end else begin
      carry_in = flag_c;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a legal accept starts the fixed EXEC/WB sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && op_legal) state_d = EXEC;
      EXEC: state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch ALU operands, op, carry-in and destination on a legal accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUA       <= '0;
      ALUB       <= '0;
      ALUcontrol <= '0;
      ALUFLAGin  <= 1'b0;
      rd_q       <= '0;
    end else if (accept && op_legal) begin
      ALUA       <= rf[instr.instr_ra];
      ALUB       <= operand_b;
      ALUcontrol <= instr.instr_op;
      ALUFLAGin  <= carry_in;
      rd_q       <= instr.instr_rd;
    end
  end

  // Capture the settled ALU result and flags at the edge that ends WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
      wb_valid <= 1'b0;
      wb_data  <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (state_q == WB) begin
        rf[rd_q] <= ALUresult;
        wb_data  <= ALUresult;
        flag_z   <= ALUflags[1];
        flag_c   <= ALUflags[0];
        wb_valid <= 1'b1;
      end
    end
  end

  // One-cycle error pulse when an illegal op is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= accept && !op_legal;
    end
  end

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Directed bench for alu_operand_ctrl with a behavioural ALU attached.
module tb_alu_operand_ctrl;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] ALUA;
  logic [N-1:0] ALUB;
  logic [3:0]   ALUcontrol;
  logic         ALUFLAGin;
  logic [N-1:0] ALUresult;
  logic [1:0]   ALUflags;
  logic         wb_valid;
  logic [N-1:0] wb_data;
  logic         err;
  logic         flag_z;
  logic         flag_c;
  logic [1:0]   dbg_addr;
  logic [N-1:0] dbg_data;

  int checks = 0;
  int fails  = 0;

  alu_operand_ctrl_if #(.n(N), .AW(2)) bus ();

  alu_operand_ctrl #(.n(N), .NREG(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (bus.slave),
    .ALUA       (ALUA),
    .ALUB       (ALUB),
    .ALUcontrol (ALUcontrol),
    .ALUFLAGin  (ALUFLAGin),
    .ALUresult  (ALUresult),
    .ALUflags   (ALUflags),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .err        (err),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference ALU: AND/OR pass carry through, ADD gives carry, SUB gives borrow.
  always_comb begin
    logic [N:0] wide;
    logic       c;
    wide = '0;
    c    = 1'b0;
    case (ALUcontrol)
      4'b0000: begin wide = {1'b0, ALUA & ALUB}; c = ALUFLAGin; end
      4'b0001: begin wide = {1'b0, ALUA | ALUB}; c = ALUFLAGin; end
      4'b0010: begin wide = {1'b0, ALUA} + {1'b0, ALUB} + {{N{1'b0}}, ALUFLAGin}; c = wide[N]; end
      4'b0110: begin wide = {1'b0, ALUA} - {1'b0, ALUB} - {{N{1'b0}}, ALUFLAGin}; c = wide[N]; end
      default: begin wide = '0; c = 1'b0; end
    endcase
    ALUresult = wide[N-1:0];
    ALUflags  = {(wide[N-1:0] == '0), c};
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkReg(input string tag, input logic [1:0] addr, input logic [N-1:0] expected);
    dbg_addr = addr;
    #1;
    checkOutput(tag, 32'(dbg_data), 32'(expected));
  endtask

  // Present one instruction, wait (bounded) for ready, return 1ns after the accept edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                               input logic [1:0] rb, input logic imm_en, input logic [N-1:0] imm,
                               input logic cin);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.instr_valid  = 1'b1;
    bus.instr_op     = op;
    bus.instr_rd     = rd;
    bus.instr_ra     = ra;
    bus.instr_rb     = rb;
    bus.instr_imm_en = imm_en;
    bus.instr_imm    = imm;
    bus.instr_cin    = cin;
    while (!bus.instr_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_before_accept", 32'(bus.instr_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  // Cycles counted from the accept cycle (=1) to the cycle wb_valid is high; 0 on timeout.
  task automatic waitWriteback(output int lat);
    lat = 0;
    for (int i = 2; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (wb_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int wbs;
    int busy;
    int idx;
    logic acc;

    rst_n            = 1'b0;
    dbg_addr         = '0;
    bus.instr_valid  = 1'b0;
    bus.instr_op     = '0;
    bus.instr_rd     = '0;
    bus.instr_ra     = '0;
    bus.instr_rb     = '0;
    bus.instr_imm_en = 1'b0;
    bus.instr_imm    = '0;
    bus.instr_cin    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    $display("[TB] reset state");
    checkOutput("rst_ready", 32'(bus.instr_ready), 32'd1);
    checkOutput("rst_alua", 32'(ALUA), 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_flags", 32'({flag_z, flag_c}), 32'd0);
    checkReg("rst_r0", 2'd0, 4'h0);

    $display("[TB] OR r1 = r0 | 9");
    applyStimulus(4'b0001, 2'd1, 2'd0, 2'd0, 1'b1, 4'h9, 1'b0);
    waitWriteback(lat);
    checkOutput("or_latency", 32'(lat), 32'd3);
    checkOutput("or_wb_data", 32'(wb_data), 32'h9);
    checkOutput("or_flags", 32'({flag_z, flag_c}), 32'b00);
    checkReg("or_r1", 2'd1, 4'h9);
    @(posedge clk);
    #1;
    checkOutput("or_wb_pulse_end", 32'(wb_valid), 32'd0);

    $display("[TB] ADD r2 = r1 + 7, then ADD with carry r3 = r0 + 0 + C");
    applyStimulus(4'b0010, 2'd2, 2'd1, 2'd0, 1'b1, 4'h7, 1'b0);
    waitWriteback(lat);
    checkOutput("add_wb_data", 32'(wb_data), 32'h0);
    checkOutput("add_flags", 32'({flag_z, flag_c}), 32'b11);
    checkReg("add_r2", 2'd2, 4'h0);
    applyStimulus(4'b0010, 2'd3, 2'd0, 2'd0, 1'b1, 4'h0, 1'b1);
    checkOutput("adc_flagin", 32'(ALUFLAGin), 32'd1);
    waitWriteback(lat);
    checkOutput("adc_flags", 32'({flag_z, flag_c}), 32'b00);
    checkReg("adc_r3", 2'd3, 4'h1);

    $display("[TB] SUB r3 = r0 - 5, then AND r0 = r0 & r0");
    applyStimulus(4'b0110, 2'd3, 2'd0, 2'd0, 1'b1, 4'h5, 1'b0);
    checkOutput("sub_flagin", 32'(ALUFLAGin), 32'd0);
    waitWriteback(lat);
    checkOutput("sub_flags", 32'({flag_z, flag_c}), 32'b01);
    checkReg("sub_r3", 2'd3, 4'hB);
    applyStimulus(4'b0000, 2'd0, 2'd0, 2'd0, 1'b0, 4'h0, 1'b0);
    checkOutput("and_flagin", 32'(ALUFLAGin), 32'd1);
    waitWriteback(lat);
    checkOutput("and_flags", 32'({flag_z, flag_c}), 32'b11);

    $display("[TB] illegal op 0011");
    applyStimulus(4'b0011, 2'd3, 2'd1, 2'd0, 1'b1, 4'hF, 1'b0);
    checkOutput("ill_err", 32'(err), 32'd1);
    checkOutput("ill_ready", 32'(bus.instr_ready), 32'd1);
    wbs = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (wb_valid) wbs++;
      if (i == 0) checkOutput("ill_err_pulse_end", 32'(err), 32'd0);
    end
    checkOutput("ill_no_write", 32'(wbs), 32'd0);
    checkOutput("ill_flags", 32'({flag_z, flag_c}), 32'b11);
    checkReg("ill_r3", 2'd3, 4'hB);

    $display("[TB] three back-to-back ADD r1 = r1 + 1 with valid held");
    @(negedge clk);
    bus.instr_valid  = 1'b1;
    bus.instr_op     = 4'b0010;
    bus.instr_rd     = 2'd1;
    bus.instr_ra     = 2'd1;
    bus.instr_rb     = 2'd0;
    bus.instr_imm_en = 1'b1;
    bus.instr_imm    = 4'h1;
    bus.instr_cin    = 1'b0;
    @(posedge clk);
    idx  = 0;
    acc  = 1'b1;
    wbs  = 0;
    busy = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx >= 3) bus.instr_valid = 1'b0;
      end
      if (wb_valid) wbs++;
      if (!bus.instr_ready) busy++;
      acc = bus.instr_ready && bus.instr_valid;
    end
    checkOutput("b2b_writes", 32'(wbs), 32'd3);
    checkOutput("b2b_busy_cycles", 32'(busy), 32'd6);
    checkOutput("b2b_flags", 32'({flag_z, flag_c}), 32'b00);
    checkReg("b2b_r1", 2'd1, 4'hC);

    $display("[TB] reset asserted during EXEC");
    applyStimulus(4'b0010, 2'd2, 2'd1, 2'd0, 1'b1, 4'h3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_alub", 32'(ALUB), 32'd0);
    checkOutput("abort_aluctl", 32'({ALUcontrol, ALUFLAGin}), 32'd0);
    checkOutput("abort_flags", 32'({flag_z, flag_c}), 32'b00);
    checkReg("abort_r1", 2'd1, 4'h0);
    checkReg("abort_r3", 2'd3, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wbs = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (wb_valid) wbs++;
    end
    checkOutput("abort_no_wb", 32'(wbs), 32'd0);
    checkOutput("abort_ready", 32'(bus.instr_ready), 32'd1);
    checkReg("abort_r2", 2'd2, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
